// File: rtl/axi_bram_responder_pkg.sv
// Shared types and helpers for the AXI4 BRAM responder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Optional feature macro: AXI_BRAM_RESPONDER_WRAP_EN enables WRAP burst support.
package axi_bram_responder_pkg;

    localparam int AXI_ID_W   = 6;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ
    } state_t;

    // One buffered read beat: response code, last flag and data word.
    typedef struct packed {
        axi_resp_t             resp;
        logic                  last;
        logic [AXI_DATA_W-1:0] data;
    } rd_beat_t;

    localparam int RD_BEAT_W = $bits(rd_beat_t);

    // Size/burst combinations this responder cannot serve.
    function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
        logic err;
        err = (size > 3'd2) || (burst == 2'b11);
`ifndef AXI_BRAM_RESPONDER_WRAP_EN
        err = err || (burst == WRAP);
`endif
        return err;
    endfunction

`ifdef AXI_BRAM_RESPONDER_WRAP_EN
    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
`endif

endpackage

// File: rtl/axi_bram_rd_buffer.sv
// Two-entry FIFO holding returned BRAM read words until the R channel accepts them.
// Latency: a word written in cycle N is visible at the output in cycle N+1.
// Backpressure: o_full / o_almost_full let the producer throttle; head stays stable while not popped.
// Ports: i_wr_vld/i_wr_dat push side, o_rd_vld/i_rd_rdy/o_rd_dat pop side, o_full/o_almost_full status.
module axi_bram_rd_buffer #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    output logic         o_rd_vld,
    input  logic         i_rd_rdy,
    output logic [W-1:0] o_rd_dat,
    output logic         o_full,
    output logic         o_almost_full
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_push        = i_wr_vld && (r_count != 2'd2);
    assign w_pop         = o_rd_vld && i_rd_rdy;
    assign o_rd_vld      = (r_count != 2'd0);
    assign o_rd_dat      = r_mem[r_rd_ptr];
    assign o_full        = (r_count == 2'd2);
    assign o_almost_full = (r_count == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/axi_bram_responder.sv
// AXI4 slave serving one burst at a time from a single-port BRAM, alternating reads/writes on contention.
// Latency: first R beat 2 cycles after AR handshake; B one cycle after the final W beat.
// Backpressure: R stalls hold data in a 2-entry buffer and throttle BRAM reads; B holds until bready.
// Ports: s_axi_aw*/w*/b*/ar*/r* AXI4 slave (6-bit ID, 32-bit data), bram_* single-port BRAM master.
// Optional feature macro: AXI_BRAM_RESPONDER_WRAP_EN (WRAP bursts; otherwise WRAP returns SLVERR).
module axi_bram_responder
    import axi_bram_responder_pkg::*;
#(
    parameter int MEM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [AXI_ID_W-1:0]   s_axi_awid,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [AXI_DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [AXI_ID_W-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [AXI_ID_W-1:0]   s_axi_arid,
    input  logic [31:0]           s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [AXI_ID_W-1:0]   s_axi_rid,
    output logic [AXI_DATA_W-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic [MEM_ADDR_W-1:0] bram_addr,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [AXI_DATA_W-1:0] bram_din,
    input  logic [AXI_DATA_W-1:0] bram_dout
);

    state_t              r_state;
    logic                r_pref_wr;       // contested grant goes to writes when set
    logic [AXI_ID_W-1:0] r_id;
    logic [31:0]         r_addr;
    logic [8:0]          r_beats;         // writes: beats left; reads: BRAM reads left to issue
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic                r_err;
    logic                r_wlast_err;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_inflight;      // a BRAM read was issued last cycle
    logic                r_inflight_last;
`ifdef AXI_BRAM_RESPONDER_WRAP_EN
    logic [31:0]         r_wrap_mask;
`endif

    logic                w_idle, w_aw_grant, w_ar_grant;
    logic                w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
    logic [AXI_ID_W-1:0] w_cap_id;
    logic [31:0]         w_cap_addr;
    logic [7:0]          w_cap_len;
    logic [2:0]          w_cap_size;
    logic [1:0]          w_cap_burst;
    logic                w_cap_err;
    logic                w_wlast_bad;
    logic                w_issue;
    logic                w_full, w_afull;
    logic [31:0]         w_inc, w_next_addr;
    rd_beat_t            w_push_beat, w_head;
    logic [RD_BEAT_W-1:0] w_head_raw;

    // Arbitration: readies only in IDLE, at most one at a time.
    assign w_idle        = (r_state == ST_IDLE) && !rst;
    assign w_aw_grant    = s_axi_awvalid && (!s_axi_arvalid || r_pref_wr);
    assign w_ar_grant    = s_axi_arvalid && !w_aw_grant;
    assign s_axi_awready = w_idle && w_aw_grant;
    assign s_axi_arready = w_idle && w_ar_grant;
    assign s_axi_wready  = (r_state == ST_WRITE) && !rst;
    assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_r_hs        = s_axi_rvalid && s_axi_rready;
    assign w_wlast_bad   = s_axi_wlast != (r_beats == 9'd1);

    always_comb begin
        w_cap_id    = w_aw_hs ? s_axi_awid    : s_axi_arid;
        w_cap_addr  = w_aw_hs ? s_axi_awaddr  : s_axi_araddr;
        w_cap_len   = w_aw_hs ? s_axi_awlen   : s_axi_arlen;
        w_cap_size  = w_aw_hs ? s_axi_awsize  : s_axi_arsize;
        w_cap_burst = w_aw_hs ? s_axi_awburst : s_axi_arburst;
        w_cap_err   = req_err(w_cap_size, w_cap_burst);
`ifdef AXI_BRAM_RESPONDER_WRAP_EN
        if (w_cap_burst == WRAP && !wrap_len_ok(w_cap_len)) begin
            w_cap_err = 1'b1;
        end
`endif
    end

    // Issue a read only if the buffer cannot overflow, counting the word in flight
    // and crediting a word leaving on R this cycle.
    assign w_issue = (r_state == ST_READ) && !rst && (r_beats != 9'd0) &&
                     (w_r_hs || (!w_full && !(w_afull && r_inflight)));

    // Error transactions still step through their beats, but never touch the BRAM.
    assign bram_en   = (w_issue || w_w_hs) && !r_err;
    assign bram_we   = (w_w_hs && !r_err) ? s_axi_wstrb : 4'd0;
    assign bram_din  = (w_w_hs && !r_err) ? s_axi_wdata : '0;
    assign bram_addr = bram_en ? r_addr[MEM_ADDR_W+1:2] : '0;

    assign w_inc = 32'd1 << r_size;
    always_comb begin
        case (r_burst)
            INCR:    w_next_addr = r_addr + w_inc;
`ifdef AXI_BRAM_RESPONDER_WRAP_EN
            // Low bits advance within the (len+1)*2^size window, high bits stay at its base.
            WRAP:    w_next_addr = (r_addr & ~r_wrap_mask) | ((r_addr + w_inc) & r_wrap_mask);
`endif
            default: w_next_addr = r_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pref_wr       <= 1'b1;
            r_id            <= '0;
            r_addr          <= '0;
            r_beats         <= '0;
            r_size          <= '0;
            r_burst         <= '0;
            r_err           <= 1'b0;
            r_wlast_err     <= 1'b0;
            r_bvalid        <= 1'b0;
            r_bresp         <= OKAY;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
`ifdef AXI_BRAM_RESPONDER_WRAP_EN
            r_wrap_mask     <= '0;
`endif
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_beats == 9'd1);
            if (w_aw_hs || w_ar_hs) begin
                r_id        <= w_cap_id;
                r_addr      <= w_cap_addr;
                r_beats     <= {1'b0, w_cap_len} + 9'd1;
                r_size      <= w_cap_size;
                r_burst     <= w_cap_burst;
                r_err       <= w_cap_err;
                r_wlast_err <= 1'b0;
`ifdef AXI_BRAM_RESPONDER_WRAP_EN
                r_wrap_mask <= (({24'd0, w_cap_len} + 32'd1) << w_cap_size) - 32'd1;
`endif
            end else if (w_issue || w_w_hs) begin
                r_addr <= w_next_addr;
            end
            case (r_state)
                ST_IDLE: begin
                    // The toggle only moves when both channels competed.
                    if (w_aw_hs) begin
                        r_state <= ST_WRITE;
                        if (s_axi_arvalid) r_pref_wr <= 1'b0;
                    end else if (w_ar_hs) begin
                        r_state <= ST_READ;
                        if (s_axi_awvalid) r_pref_wr <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_w_hs) begin
                        r_beats <= r_beats - 9'd1;
                        if (w_wlast_bad) r_wlast_err <= 1'b1;
                        if (r_beats == 9'd1) begin
                            r_state  <= ST_WRESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_err || r_wlast_err || w_wlast_bad) ? SLVERR : OKAY;
                        end
                    end
                end
                ST_WRESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (w_issue) r_beats <= r_beats - 9'd1;
                    if (w_r_hs && s_axi_rlast) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_push_beat.resp = r_err ? SLVERR : OKAY;
        w_push_beat.last = r_inflight_last;
        w_push_beat.data = r_err ? '0 : bram_dout;
    end

    axi_bram_rd_buffer #(
        .W (RD_BEAT_W)
    ) u_rd_buffer (
        .clk           (clk),
        .rst           (rst),
        .i_wr_vld      (r_inflight),
        .i_wr_dat      (w_push_beat),
        .o_rd_vld      (s_axi_rvalid),
        .i_rd_rdy      (s_axi_rready),
        .o_rd_dat      (w_head_raw),
        .o_full        (w_full),
        .o_almost_full (w_afull)
    );

    assign w_head       = rd_beat_t'(w_head_raw);
    assign s_axi_rdata  = w_head.data;
    assign s_axi_rresp  = w_head.resp;
    assign s_axi_rlast  = w_head.last;
    assign s_axi_rid    = r_id;
    assign s_axi_bid    = r_id;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;

endmodule

// File: tb/tb_axi_bram_responder.sv
// Scoreboarded bench for axi_bram_responder with a behavioural BRAM.
// Latency: n/a (bench).
// Backpressure: exercises R stalls through a toggling rready.
module tb_axi_bram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [5:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic [5:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [5:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rvalid, s_axi_rready;
    logic [5:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic [13:0] bram_addr;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    axi_bram_responder #(.MEM_ADDR_W(14)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port BRAM, read-first, one cycle read latency.
    logic [31:0] mem [0:16383];
    int          en_cnt = 0;
    int          cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_en) begin
            en_cnt <= en_cnt + 1;
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
            end
            bram_dout <= mem[bram_addr];
        end
    end

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [5:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [5:0] id; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];

    int n_vec = 0;
    int n_err = 0;
    int aw_cyc, ar_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic [5:0] id);
        rexp_t e;
        e.data = d; e.resp = resp; e.last = last; e.id = id;
        rq.push_back(e);
    endtask

    task automatic exp_b(input logic [1:0] resp, input logic [5:0] id);
        bexp_t e;
        e.resp = resp; e.id = id;
        bq.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every R/B handshake and checks R stability during stalls.
    logic        stall_prev = 1'b0;
    logic [32:0] held;
    rexp_t       mon_r;
    bexp_t       mon_b;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (s_axi_awready || s_axi_arready)
                check("ready_exclusive", {63'd0, s_axi_awready && s_axi_arready}, 64'd0);
            if (stall_prev && s_axi_rvalid)
                check("r_hold", {31'd0, s_axi_rdata, s_axi_rlast}, {31'd0, held});
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_r = rq.pop_front();
                    check("r_beat", {23'd0, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata},
                          {23'd0, mon_r.id, mon_r.resp, mon_r.last, mon_r.data});
                end
            end
            stall_prev = s_axi_rvalid && !s_axi_rready;
            held       = {s_axi_rdata, s_axi_rlast};
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_b = bq.pop_front();
                    check("b_resp", {56'd0, s_axi_bid, s_axi_bresp}, {56'd0, mon_b.id, mon_b.resp});
                end
            end
        end
    end

    task automatic send_aw(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_axi_awready) begin ok = 1; break; end
        end
        check("aw_accepted", {63'd0, ok}, 64'd1);
        @(posedge clk);
        aw_cyc = cyc;
        #1 s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len; s_axi_arsize = size;
        s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_axi_arready) begin ok = 1; break; end
        end
        check("ar_accepted", {63'd0, ok}, 64'd1);
        @(posedge clk);
        ar_cyc = cyc;
        #1 s_axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
        bit ok = 0;
        s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_axi_wready) begin ok = 1; break; end
        end
        check("w_accepted", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1 s_axi_wvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        check(name, 64'(rq.size() + bq.size()), 64'd0);
        rq.delete();
        bq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_axi_awvalid = 0; s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
        s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, bram_en, bram_we,
               bram_addr, s_axi_rresp, s_axi_bresp, s_axi_rid, s_axi_bid, s_axi_rlast}, 64'd0);
        check("reset_data", {bram_din, s_axi_rdata}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {s_axi_awready, s_axi_arready, s_axi_rvalid, s_axi_bvalid, bram_en}, 64'd0);
        @(posedge clk); #1;

        // Single write then read with first-beat latency check.
        exp_b(2'b00, 6'd1);
        send_aw(6'd1, 32'h100, 8'd0, 3'd2, 2'b01);
        send_w(32'hDEADBEEF, 4'hF, 1'b1);
        drain("single_write_done");
        exp_r(32'hDEADBEEF, 2'b00, 1'b1, 6'd2);
        send_ar(6'd2, 32'h100, 8'd0, 3'd2, 2'b01);
        @(negedge clk); check("rd_latency_c0", {63'd0, s_axi_rvalid}, 64'd0);
        @(negedge clk); check("rd_latency_c1", {63'd0, s_axi_rvalid}, 64'd0);
        @(negedge clk); check("rd_latency_c2", {63'd0, s_axi_rvalid}, 64'd1);
        drain("single_read_done");

        // 16-beat INCR write, then read back with rready toggling every cycle.
        exp_b(2'b00, 6'd3);
        send_aw(6'd3, 32'h200, 8'd15, 3'd2, 2'b01);
        for (int i = 0; i < 16; i++) send_w(32'(i), 4'hF, i == 15);
        drain("burst_write_done");
        for (int i = 0; i < 16; i++) exp_r(32'(i), 2'b00, i == 15, 6'd4);
        fork
            send_ar(6'd4, 32'h200, 8'd15, 3'd2, 2'b01);
            for (int t = 0; t < 300 && rq.size() != 0; t++) begin
                @(posedge clk);
                #1 s_axi_rready = ~s_axi_rready;
            end
        join
        s_axi_rready = 1'b1;
        drain("burst_read_done");

        // Simultaneous AW+AR: write first after reset, then read first.
        exp_b(2'b00, 6'd5);
        exp_r(32'hDEADBEEF, 2'b00, 1'b1, 6'd6);
        fork
            begin send_aw(6'd5, 32'h300, 8'd0, 3'd2, 2'b01); send_w(32'hA5A50001, 4'hF, 1'b1); end
            send_ar(6'd6, 32'h100, 8'd0, 3'd2, 2'b01);
        join
        check("grant_write_first", {63'd0, aw_cyc < ar_cyc}, 64'd1);
        drain("pair1_done");
        exp_r(32'hA5A50001, 2'b00, 1'b1, 6'd8);
        exp_b(2'b00, 6'd7);
        fork
            begin send_aw(6'd7, 32'h304, 8'd0, 3'd2, 2'b01); send_w(32'h5A5A0002, 4'hF, 1'b1); end
            send_ar(6'd8, 32'h300, 8'd0, 3'd2, 2'b01);
        join
        check("grant_read_second", {63'd0, ar_cyc < aw_cyc}, 64'd1);
        drain("pair2_done");

        // Read with size 3: SLVERR, zero data, BRAM untouched.
        begin
            int en0;
            en0 = en_cnt;
            for (int i = 0; i < 4; i++) exp_r(32'd0, 2'b10, i == 3, 6'd9);
            send_ar(6'd9, 32'h100, 8'd3, 3'd3, 2'b01);
            drain("err_read_done");
            check("err_read_no_bram_en", 64'(en_cnt - en0), 64'd0);
        end

        // Early wlast: SLVERR, all four beats still written.
        exp_b(2'b10, 6'd10);
        send_aw(6'd10, 32'h400, 8'd3, 3'd2, 2'b01);
        send_w(32'h11, 4'hF, 1'b0);
        send_w(32'h22, 4'hF, 1'b1);
        send_w(32'h33, 4'hF, 1'b0);
        send_w(32'h44, 4'hF, 1'b1);
        drain("wlast_err_done");
        exp_r(32'h11, 2'b00, 1'b0, 6'd11); exp_r(32'h22, 2'b00, 1'b0, 6'd11);
        exp_r(32'h33, 2'b00, 1'b0, 6'd11); exp_r(32'h44, 2'b00, 1'b1, 6'd11);
        send_ar(6'd11, 32'h400, 8'd3, 3'd2, 2'b01);
        drain("wlast_readback_done");

        // Size-3 write must not modify memory; reserved burst read is SLVERR.
        exp_b(2'b10, 6'd12);
        send_aw(6'd12, 32'h100, 8'd0, 3'd3, 2'b01);
        send_w(32'h12345678, 4'hF, 1'b1);
        drain("err_write_done");
        exp_r(32'hDEADBEEF, 2'b00, 1'b1, 6'd13);
        send_ar(6'd13, 32'h100, 8'd0, 3'd2, 2'b01);
        drain("err_write_readback");
        exp_r(32'd0, 2'b10, 1'b1, 6'd14);
        send_ar(6'd14, 32'h100, 8'd0, 3'd2, 2'b11);
        drain("reserved_burst_done");

        // WRAP: 0x38 len 3 visits words 0x0E,0x0F,0x0C,0x0D.
        exp_b(2'b00, 6'd15);
        send_aw(6'd15, 32'h30, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'hC0DE0030 + 32'(4 * i), 4'hF, i == 3);
        drain("wrap_prefill_done");
`ifdef AXI_BRAM_RESPONDER_WRAP_EN
        exp_r(32'hC0DE0038, 2'b00, 1'b0, 6'd16); exp_r(32'hC0DE003C, 2'b00, 1'b0, 6'd16);
        exp_r(32'hC0DE0030, 2'b00, 1'b0, 6'd16); exp_r(32'hC0DE0034, 2'b00, 1'b1, 6'd16);
`else
        for (int i = 0; i < 4; i++) exp_r(32'd0, 2'b10, i == 3, 6'd16);
`endif
        send_ar(6'd16, 32'h38, 8'd3, 3'd2, 2'b10);
        drain("wrap_read_done");
        for (int i = 0; i < 3; i++) exp_r(32'd0, 2'b10, i == 2, 6'd17);
        send_ar(6'd17, 32'h38, 8'd2, 3'd2, 2'b10);
        drain("wrap_badlen_done");

        // Reset in the middle of an 8-beat read, after beat 3.
        for (int i = 0; i < 8; i++) exp_r(32'(i), 2'b00, i == 7, 6'd18);
        send_ar(6'd18, 32'h200, 8'd7, 3'd2, 2'b01);
        for (int t = 0; t < 100 && rq.size() > 5; t++) @(posedge clk);
        #1 rst = 1'b1; s_axi_rready = 1'b0;
        s_axi_arid = 6'd19; s_axi_araddr = 32'h200; s_axi_arlen = 8'd1;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rvalid", {63'd0, s_axi_rvalid}, 64'd0);
        check("rst_mid_arready", {63'd0, s_axi_arready}, 64'd0);
        check("rst_mid_bvalid", {63'd0, s_axi_bvalid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        rq.delete();
        exp_r(32'd0, 2'b00, 1'b0, 6'd19); exp_r(32'd1, 2'b00, 1'b1, 6'd19);
        send_ar(6'd19, 32'h200, 8'd1, 3'd2, 2'b01);
        drain("post_reset_read_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
